// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer behind the sale FSM: motor run with done/timeout, unit-coin change payout.
// Define VEND_CTRL_REFUND_EN to refund the full credit after a motor timeout instead of locking up.
module vend_dispense_ctrl #(
  parameter int unsigned PRICE_A       = 2,
  parameter int unsigned PRICE_B       = 3,
  parameter int unsigned MOTOR_TIMEOUT = 200,
  parameter int unsigned COIN_GAP      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vend_a,
  input  logic       vend_b,
  input  logic [3:0] credit,
  input  logic       motor_done,
  output logic       motor_a,
  output logic       motor_b,
  output logic       coin_out,
  output logic       credit_clr,
  output logic       busy,
  output logic       reject,
  output logic       overrun,
  output logic       fault
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StMotor  = 3'd1;
  localparam logic [2:0] StChange = 3'd2;
  localparam logic [2:0] StGap    = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;
  localparam logic [2:0] StFault  = 3'd5;

  localparam logic [3:0] PriceA    = 4'(PRICE_A);
  localparam logic [3:0] PriceB    = 4'(PRICE_B);
  localparam logic [7:0] MotorLast = 8'(MOTOR_TIMEOUT - 1);
  localparam logic [7:0] GapLast   = 8'(COIN_GAP - 1);

  logic [2:0] state_d, state_q;
  logic       prod_b_d, prod_b_q;
  logic [3:0] change_d, change_q;
  logic [7:0] cnt_d, cnt_q;
  logic       overrun_d, overrun_q;
  logic       fault_d, fault_q;
  logic       reject_d, reject_q;
  logic       motor_a_d, motor_a_q;
  logic       motor_b_d, motor_b_q;
  logic       coin_out_d, coin_out_q;
  logic       credit_clr_d, credit_clr_q;
  logic       busy_d, busy_q;
  logic       req;
  logic [3:0] price;
`ifdef VEND_CTRL_REFUND_EN
  logic [3:0] credit_d, credit_q;
`endif

  // B has priority; a simultaneous A request is dropped without any flag.
  assign req   = vend_a | vend_b;
  assign price = vend_b ? PriceB : PriceA;

  always_comb begin
    state_d   = state_q;
    prod_b_d  = prod_b_q;
    change_d  = change_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    fault_d   = fault_q;
    reject_d  = 1'b0;
`ifdef VEND_CTRL_REFUND_EN
    credit_d  = credit_q;
`endif

    if (state_q != StIdle && req) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (req) begin
          if (credit >= price) begin
            prod_b_d = vend_b;
            change_d = credit - price;
            cnt_d    = 8'd0;
            state_d  = StMotor;
`ifdef VEND_CTRL_REFUND_EN
            credit_d = credit;
`endif
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      StMotor: begin
        if (motor_done) begin
          cnt_d   = 8'd0;
          state_d = (change_q != 4'd0) ? StChange : StDone;
        end else if (cnt_q == MotorLast) begin
          fault_d = 1'b1;
          cnt_d   = 8'd0;
`ifdef VEND_CTRL_REFUND_EN
          change_d = credit_q;
          state_d  = (credit_q != 4'd0) ? StChange : StDone;
`else
          state_d  = StFault;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StChange: begin
        change_d = change_q - 4'd1;
        cnt_d    = 8'd0;
        state_d  = StGap;
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = 8'd0;
          state_d = (change_q != 4'd0) ? StChange : StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so each one is a flop that tracks the state register.
  always_comb begin
    motor_a_d    = (state_d == StMotor) && !prod_b_d;
    motor_b_d    = (state_d == StMotor) && prod_b_d;
    coin_out_d   = (state_d == StChange);
    credit_clr_d = (state_d == StDone);
    busy_d       = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      prod_b_q     <= 1'b0;
      change_q     <= 4'd0;
      cnt_q        <= 8'd0;
      overrun_q    <= 1'b0;
      fault_q      <= 1'b0;
      reject_q     <= 1'b0;
      motor_a_q    <= 1'b0;
      motor_b_q    <= 1'b0;
      coin_out_q   <= 1'b0;
      credit_clr_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prod_b_q     <= prod_b_d;
      change_q     <= change_d;
      cnt_q        <= cnt_d;
      overrun_q    <= overrun_d;
      fault_q      <= fault_d;
      reject_q     <= reject_d;
      motor_a_q    <= motor_a_d;
      motor_b_q    <= motor_b_d;
      coin_out_q   <= coin_out_d;
      credit_clr_q <= credit_clr_d;
      busy_q       <= busy_d;
    end
  end

`ifdef VEND_CTRL_REFUND_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_q <= 4'd0;
    end else begin
      credit_q <= credit_d;
    end
  end
`endif

  assign motor_a    = motor_a_q;
  assign motor_b    = motor_b_q;
  assign coin_out   = coin_out_q;
  assign credit_clr = credit_clr_q;
  assign busy       = busy_q;
  assign reject     = reject_q;
  assign overrun    = overrun_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Scoreboard bench: expected per-cycle output vectors are queued as each request is driven,
// then popped and compared one per cycle on the falling edge.
module tb_vend_dispense_ctrl;

  localparam int PriceA   = 2;
  localparam int PriceB   = 3;
  localparam int Timeout  = 200;
  localparam int CoinGap  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vend_a = 1'b0;
  logic       vend_b = 1'b0;
  logic [3:0] credit = 4'd0;
  logic       motor_done = 1'b0;
  logic       motor_a, motor_b, coin_out, credit_clr, busy, reject, overrun, fault;

  int    errors = 0;
  int    checks = 0;
  string tname;

  // Vector layout: {motor_a, motor_b, coin_out, credit_clr, busy, reject}
  logic [5:0] exp_q[$];

  vend_dispense_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .vend_a     (vend_a),
    .vend_b     (vend_b),
    .credit     (credit),
    .motor_done (motor_done),
    .motor_a    (motor_a),
    .motor_b    (motor_b),
    .coin_out   (coin_out),
    .credit_clr (credit_clr),
    .busy       (busy),
    .reject     (reject),
    .overrun    (overrun),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {motor_a, motor_b, coin_out, credit_clr, busy, reject};
  endfunction

  task automatic check_bit(input string what, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s/%s: got %b expected %b", tname, what, got, want);
    end
  endtask

  // Expected trace of one accepted sale: motor phase, coin/gap pairs, then done+idle or lock-up.
  task automatic push_sale(input bit is_b, input int motor_cycles, input int coins,
                           input bit locked);
    for (int i = 0; i < motor_cycles; i++) exp_q.push_back({~is_b, is_b, 4'b0010});
    for (int c = 0; c < coins; c++) begin
      exp_q.push_back(6'b001010);
      for (int g = 0; g < CoinGap; g++) exp_q.push_back(6'b000010);
    end
    if (locked) begin
      for (int i = 0; i < 6; i++) exp_q.push_back(6'b000010);
    end else begin
      exp_q.push_back(6'b000110);
      exp_q.push_back(6'b000000);
    end
  endtask

  task automatic start_req(input logic a, input logic b, input logic [3:0] c);
    @(negedge clk);
    vend_a = a;
    vend_b = b;
    credit = c;
    @(negedge clk);
    vend_a = 1'b0;
    vend_b = 1'b0;
  endtask

  // Pops one expected vector per cycle; done_idx/stray_idx select the cycle where motor_done or a
  // stray vend_a is presented (sampled at the next rising edge).
  task automatic play(input int done_idx, input int stray_idx);
    int i;
    logic [5:0] want;
    i = 0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (outs() !== want) begin
        errors++;
        $display("FAIL %s cycle %0d: got %b expected %b", tname, i, outs(), want);
      end
      motor_done = (i == done_idx);
      vend_a     = (i == stray_idx);
      i++;
      @(negedge clk);
    end
    motor_done = 1'b0;
    vend_a     = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tname = "reset";
    #2;
    check_bit("outs_in_reset", |outs(), 1'b0);
    check_bit("overrun_in_reset", overrun, 1'b0);
    check_bit("fault_in_reset", fault, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_bit("outs_after_release", |outs(), 1'b0);
  endtask

  task automatic test_b_sale();
    tname = "b_sale";
    start_req(1'b0, 1'b1, 4'd5);
    push_sale(1'b1, 3, 5 - PriceB, 1'b0);
    play(2, -1);
    check_bit("overrun", overrun, 1'b0);
    check_bit("fault", fault, 1'b0);
  endtask

  task automatic test_simultaneous();
    tname = "simultaneous";
    start_req(1'b1, 1'b1, 4'd3);
    push_sale(1'b1, 2, 3 - PriceB, 1'b0);
    play(1, -1);
    check_bit("overrun", overrun, 1'b0);
  endtask

  task automatic test_reject();
    tname = "reject";
    start_req(1'b1, 1'b0, 4'd1);
    exp_q.push_back(6'b000001);
    exp_q.push_back(6'b000000);
    exp_q.push_back(6'b000000);
    play(-1, -1);
  endtask

  task automatic test_overrun();
    tname = "overrun";
    start_req(1'b0, 1'b1, 4'd5);
    push_sale(1'b1, 3, 5 - PriceB, 1'b0);
    // Index 5 falls in the first GAP (motor 0..2, coin 3, gap 4..7).
    play(2, 5);
    check_bit("overrun_set", overrun, 1'b1);
    tname = "overrun_second_sale";
    start_req(1'b1, 1'b0, 4'd3);
    push_sale(1'b0, 1, 3 - PriceA, 1'b0);
    play(0, -1);
    check_bit("overrun_sticky", overrun, 1'b1);
    apply_reset();
    check_bit("overrun_cleared", overrun, 1'b0);
  endtask

  task automatic test_reset_mid_change();
    tname = "reset_mid_change";
    start_req(1'b1, 1'b0, 4'd5);
    for (int i = 0; i < 2; i++) exp_q.push_back(6'b100010);
    play(1, -1);
    check_bit("first_coin", coin_out, 1'b1);
    reset = 1'b1;
    #1;
    check_bit("outs_async_drop", |outs(), 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) exp_q.push_back(6'b000000);
    play(-1, -1);
  endtask

  task automatic test_timeout();
    tname = "timeout";
    check_bit("fault_before", fault, 1'b0);
    start_req(1'b1, 1'b0, 4'd4);
`ifdef VEND_CTRL_REFUND_EN
    push_sale(1'b0, Timeout, 4, 1'b0);
`else
    push_sale(1'b0, Timeout, 0, 1'b1);
`endif
    play(-1, -1);
    check_bit("fault_set", fault, 1'b1);
`ifdef VEND_CTRL_REFUND_EN
    tname = "timeout_sale_after";
    start_req(1'b0, 1'b1, 4'd4);
    push_sale(1'b1, 2, 4 - PriceB, 1'b0);
    play(1, -1);
    check_bit("fault_sticky", fault, 1'b1);
`else
    check_bit("busy_locked", busy, 1'b1);
`endif
  endtask

  initial begin
    test_reset();
    test_b_sale();
    test_simultaneous();
    test_reject();
    test_overrun();
    test_reset_mid_change();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
